// File: rtl/mem_access_if.sv
// mem_access_if: CPU request/response and memory-controller bus bundle
interface mem_access_if;
  logic        req;
  logic        wr;
  logic [15:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        done;
  logic        fault;
  logic [31:0] rdata;
  logic [15:0] mem_address;
  logic [31:0] mem_data_in;
  logic        mem_we;
  logic [31:0] mem_data_out;
  modport slave (
    input  req, wr, addr, wdata, mem_data_out,
    output ready, done, fault, rdata, mem_address, mem_data_in, mem_we
  );
  modport master (
    output req, wr, addr, wdata, mem_data_out,
    input  ready, done, fault, rdata, mem_address, mem_data_in, mem_we
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: sequences one CPU load/store onto the memory controller port (clock, reset, bus: req/wr/addr/wdata in, ready/done/fault/rdata out, mem_* controller side)
module mem_access_unit #(
  parameter int READ_WAIT = 1
) (
  input  logic clock,
  input  logic reset,
  mem_access_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ADDR, WRITE, RWAIT, FINISH, FAULT} state_t;
  state_t      state, next;
  logic        wr_q;
  logic [2:0]  cnt;
  logic [15:0] addr_q;
  logic [31:0] data_q, rdata_q;
  logic        accept, illegal;
  // legal space is 0x0000-0x003F and 0x0800-0x0FFF; the low 32 words are ROM
  assign illegal = !(bus.addr < 16'h0040 || (bus.addr >= 16'h0800 && bus.addr < 16'h1000)) || (bus.wr && bus.addr < 16'h0020);
  assign accept  = state == IDLE && bus.req;
  always_ff @(posedge clock) state <= reset ? IDLE : next;
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = bus.req ? (illegal ? FAULT : ADDR) : IDLE;
      ADDR:    next = wr_q ? WRITE : RWAIT;
      WRITE:   next = FINISH;
      RWAIT:   next = cnt == 3'd0 ? FINISH : RWAIT;
      default: next = IDLE;
    endcase
  end
  always_comb begin
    bus.ready  = state == IDLE;
    bus.done   = state == FINISH || state == FAULT;
    bus.fault  = state == FAULT;
    bus.mem_we = state == WRITE;
  end
  // RWAIT lasts READ_WAIT cycles: counter preloaded in ADDR, capture when it reaches zero
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      cnt     <= '0;
    end else begin
      if (accept && !illegal) {wr_q, addr_q, data_q} <= {bus.wr, bus.addr, bus.wdata};
      if (accept && illegal) rdata_q <= '0;
      if (state == ADDR) cnt <= 3'(READ_WAIT - 1);
      else if (state == RWAIT && cnt != 3'd0) cnt <= cnt - 3'd1;
      if (state == RWAIT && cnt == 3'd0) rdata_q <= bus.mem_data_out;
    end
  end
  assign bus.rdata       = rdata_q;
  assign bus.mem_address = addr_q;
  assign bus.mem_data_in = data_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of mem_access_unit with READ_WAIT=1 and READ_WAIT=3 side by side
module tb_mem_access_unit;
  logic        clock = 1'b0;
  logic        reset, req, wr;
  logic [15:0] addr;
  logic [31:0] wdata;
  int          checks = 0, errors = 0, stray = 0;
  int          da, db, nda, ndb, wea, wec, dn, rc, fl, k;
  logic        fa;
  logic [31:0] ra, rb, wdd;
  logic [15:0] wad;
  logic [31:0] got [3];
  logic [15:0] list [3];
  logic [31:0] mem_a [4096], mem_b [4096];
  bit          val_a [4096], val_b [4096];
  always #5 clock = ~clock;
  mem_access_if a_if ();
  mem_access_if b_if ();
  assign {a_if.req, a_if.wr, a_if.addr, a_if.wdata} = {req, wr, addr, wdata};
  assign {b_if.req, b_if.wr, b_if.addr, b_if.wdata} = {req, wr, addr, wdata};
  assign a_if.mem_data_out = val_a[a_if.mem_address[11:0]] ? mem_a[a_if.mem_address[11:0]] : {16'hA5A5, a_if.mem_address};
  assign b_if.mem_data_out = val_b[b_if.mem_address[11:0]] ? mem_b[b_if.mem_address[11:0]] : {16'hA5A5, b_if.mem_address};
  always @(posedge clock) begin
    if (a_if.mem_we) begin
      mem_a[a_if.mem_address[11:0]] <= a_if.mem_data_in;
      val_a[a_if.mem_address[11:0]] <= 1'b1;
    end
    if (b_if.mem_we) begin
      mem_b[b_if.mem_address[11:0]] <= b_if.mem_data_in;
      val_b[b_if.mem_address[11:0]] <= 1'b1;
    end
  end
  always @(negedge clock) stray <= stray + int'(a_if.fault && !a_if.done) + int'(b_if.fault && !b_if.done);
  mem_access_unit #(.READ_WAIT(1)) dut_a (.clock(clock), .reset(reset), .bus(a_if.slave));
  mem_access_unit #(.READ_WAIT(3)) dut_b (.clock(clock), .reset(reset), .bus(b_if.slave));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask
  task automatic run(input logic w, input logic [15:0] ad, input logic [31:0] wd, input logic noise);
    chk("ready_before_req", a_if.ready, 1);
    req = 1'b1; wr = w; addr = ad; wdata = wd;
    da = -1; db = -1; nda = 0; ndb = 0; wea = 0; wec = -1; fa = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clock);
      req = noise && n <= 3 && n % 2 == 1;
      if (a_if.done) begin nda++; if (da < 0) da = n; fa = a_if.fault; ra = a_if.rdata; end
      if (a_if.mem_we) begin wea++; wec = n; wad = a_if.mem_address; wdd = a_if.mem_data_in; end
      if (b_if.done) begin ndb++; if (db < 0) db = n; rb = b_if.rdata; end
    end
  endtask
  initial begin
    list[0] = 16'h0020; list[1] = 16'h0021; list[2] = 16'h0FFF;
    reset = 1'b1; req = 1'b1; wr = 1'b0; addr = 16'h0800; wdata = 32'h0;
    repeat (3) @(negedge clock);
    chk("rst_ready", a_if.ready, 1);
    chk("rst_done", a_if.done, 0);
    chk("rst_fault", a_if.fault, 0);
    chk("rst_we", a_if.mem_we, 0);
    chk("rst_rdata", a_if.rdata, 0);
    chk("rst_maddr", a_if.mem_address, 0);
    chk("rst_mdin", a_if.mem_data_in, 0);
    reset = 1'b0; req = 1'b0;
    @(negedge clock);
    chk("req_during_reset_ignored", a_if.ready, 1);
    run(1'b1, 16'h0800, 32'hDEADBEEF, 1'b0);
    chk("st_done_cycle", da, 3);
    chk("st_fault", fa, 0);
    chk("st_we_count", wea, 1);
    chk("st_we_cycle", wec, 2);
    chk("st_we_addr", wad, 16'h0800);
    chk("st_we_data", wdd, 32'hDEADBEEF);
    chk("st_done_cycle_rw3", db, 3);
    run(1'b0, 16'h0800, 32'h0, 1'b0);
    chk("ld_done_cycle_rw1", da, 3);
    chk("ld_rdata_rw1", ra, 32'hDEADBEEF);
    chk("ld_done_cycle_rw3", db, 5);
    chk("ld_rdata_rw3", rb, 32'hDEADBEEF);
    chk("ld_we_count", wea, 0);
    run(1'b1, 16'h0900, 32'h11111111, 1'b0);
    chk("st_keeps_rdata", ra, 32'hDEADBEEF);
    run(1'b1, 16'h0010, 32'h22222222, 1'b0);
    chk("rom_st_done_cycle", da, 1);
    chk("rom_st_fault", fa, 1);
    chk("rom_st_rdata", ra, 0);
    chk("rom_st_we_count", wea, 0);
    run(1'b0, 16'h0500, 32'h0, 1'b0);
    chk("hole_ld_done_cycle", da, 1);
    chk("hole_ld_fault", fa, 1);
    chk("hole_ld_rdata", ra, 0);
    chk("hole_ld_we_count", wea, 0);
    run(1'b0, 16'h0021, 32'h0, 1'b1);
    chk("noise_done_count", nda, 1);
    chk("noise_done_cycle", da, 3);
    chk("noise_rdata", ra, 32'hA5A50021);
    chk("noise_done_count_rw3", ndb, 1);
    k = 0; dn = 0; rc = 0; fl = 0;
    for (int c = 0; c < 40 && !(k == 3 && dn == 3 && a_if.ready); c++) begin
      if (a_if.done) begin
        if (dn < 3) got[dn] = a_if.rdata;
        fl += int'(a_if.fault);
        dn++;
      end
      if (a_if.ready && k > 0 && dn < 3) rc++;
      if (a_if.ready && k < 3) begin addr = list[k]; wr = 1'b0; req = 1'b1; k++; end
      @(negedge clock);
    end
    req = 1'b0;
    chk("b2b_done_count", dn, 3);
    chk("b2b_ready_gaps", rc, 2);
    chk("b2b_faults", fl, 0);
    chk("b2b_rdata0", got[0], 32'hA5A50020);
    chk("b2b_rdata1", got[1], 32'hA5A50021);
    chk("b2b_rdata2", got[2], 32'hA5A50FFF);
    for (int c = 0; c < 20 && !b_if.ready; c++) @(negedge clock);
    @(negedge clock);
    chk("b2b_rw3_idle", b_if.ready, 1);
    req = 1'b1; wr = 1'b0; addr = 16'h0800;
    @(negedge clock);
    req = 1'b0;
    @(negedge clock);
    chk("rwait_busy", b_if.ready, 0);
    reset = 1'b1;
    @(negedge clock);
    chk("rwait_rst_done", b_if.done, 0);
    chk("rwait_rst_ready", b_if.ready, 1);
    chk("rwait_rst_rdata", b_if.rdata, 0);
    chk("rwait_rst_done_rw1", a_if.done, 0);
    reset = 1'b0;
    nda = 0;
    repeat (6) begin @(negedge clock); nda += int'(a_if.done) + int'(b_if.done); end
    chk("rwait_rst_no_done", nda, 0);
    run(1'b0, 16'h0020, 32'h0, 1'b0);
    chk("post_rst_ld_cycle", da, 3);
    chk("post_rst_ld_rdata", ra, 32'hA5A50020);
    req = 1'b1; wr = 1'b1; addr = 16'h0A00; wdata = 32'h00000055;
    @(negedge clock);
    req = 1'b0;
    @(negedge clock);
    chk("write_we_high", a_if.mem_we, 1);
    reset = 1'b1;
    @(negedge clock);
    chk("write_rst_we", a_if.mem_we, 0);
    chk("write_rst_done", a_if.done, 0);
    chk("write_rst_ready", a_if.ready, 1);
    chk("write_rst_maddr", a_if.mem_address, 0);
    chk("write_rst_mdin", a_if.mem_data_in, 0);
    chk("write_rst_rdata", a_if.rdata, 0);
    reset = 1'b0;
    nda = 0; wea = 0;
    repeat (6) begin @(negedge clock); nda += int'(a_if.done); wea += int'(a_if.mem_we); end
    chk("write_rst_no_done", nda, 0);
    chk("write_rst_no_we", wea, 0);
    chk("fault_only_with_done", stray, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
